// File: rtl/sft_drv.sv
// Command-driven controller for a 74HC595-style shift register: master reset,
// serial shift (MSB first from cmd_len), storage strobe and output enable.
module sft_drv #(
    parameter int DIV = 4
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        cmd_wr,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_dat,
    output logic        busy,
    output logic        done,
    output logic        cmd_err,
    output logic        SFT_SHCP,
    output logic        SFT_DS,
    output logic        SFT_STCP,
    output logic        SFT_MR_N,
    output logic        SFT_OE_N
);

    typedef enum logic [2:0] {
        IDLE,
        MRST,
        SH_LO,
        SH_HI,
        STORE
    } state_t;

    localparam logic [7:0] PH_LAST = 8'(DIV - 1);

    state_t      state_q;
    logic [7:0]  phase_q;
    logic [4:0]  bit_q;
    logic [31:0] dat_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        shcp_q;
    logic        ds_q;
    logic        stcp_q;
    logic        mr_n_q;
    logic        oe_n_q;

    logic        ph_end_d;
    logic [4:0]  nxt_bit_d;

    always_comb begin
        ph_end_d  = (phase_q == PH_LAST);
        nxt_bit_d = bit_q - 5'd1;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            shcp_q  <= 1'b0;
            ds_q    <= 1'b0;
            stcp_q  <= 1'b0;
            mr_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= cmd_wr & busy_q;
            case (state_q)
                IDLE: begin
                    if (cmd_wr) begin
                        phase_q <= '0;
                        case (cmd_op)
                            2'b00: begin
                                state_q <= MRST;
                                busy_q  <= 1'b1;
                                mr_n_q  <= 1'b0;
                            end
                            2'b01: begin
                                state_q <= SH_LO;
                                busy_q  <= 1'b1;
                                dat_q   <= cmd_dat;
                                bit_q   <= cmd_len;
                                ds_q    <= cmd_dat[cmd_len];
                                shcp_q  <= 1'b0;
                            end
                            2'b10: begin
                                state_q <= STORE;
                                busy_q  <= 1'b1;
                                stcp_q  <= 1'b1;
                            end
                            default: begin
                                // Output enable completes in the accept cycle itself.
                                oe_n_q <= ~cmd_dat[0];
                                done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                MRST: begin
                    if (ph_end_d) begin
                        state_q <= IDLE;
                        phase_q <= '0;
                        mr_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                STORE: begin
                    if (ph_end_d) begin
                        state_q <= IDLE;
                        phase_q <= '0;
                        stcp_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                SH_LO: begin
                    if (ph_end_d) begin
                        state_q <= SH_HI;
                        phase_q <= '0;
                        shcp_q  <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                SH_HI: begin
                    if (ph_end_d) begin
                        phase_q <= '0;
                        shcp_q  <= 1'b0;
                        // Counting down to zero lets len=31 run all 32 bits without wrap.
                        if (bit_q == 5'd0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SH_LO;
                            bit_q   <= nxt_bit_d;
                            ds_q    <= dat_q[nxt_bit_d];
                        end
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cmd_err  = err_q;
    assign SFT_SHCP = shcp_q;
    assign SFT_DS   = ds_q;
    assign SFT_STCP = stcp_q;
    assign SFT_MR_N = mr_n_q;
    assign SFT_OE_N = oe_n_q;

endmodule
